// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// master: controller side (drives strobes); slave: datapath side (drives opcode).
interface multicycle_controller_if;
  logic [5:0]  opcode;
  logic        regsel;
  logic        regdst;
  logic        ALUSrcA;
  logic        memread;
  logic        memwrite;
  logic        regwrite;
  logic        memtoreg;
  logic        jal;
  logic        IorD;
  logic        IRWrite;
  logic        PCWrite;
  logic        PCWriteCond;
  logic [1:0]  PCSrc;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ALUOp;
  logic [3:0]  state;
  logic        instr_done;
  logic [31:0] retired;

  modport master (
    input  opcode,
    output regsel, regdst, ALUSrcA, memread, memwrite, regwrite, memtoreg, jal, IorD,
    output IRWrite, PCWrite, PCWriteCond, PCSrc, ALUSrcB, ALUOp, state, instr_done, retired
  );

  modport slave (
    output opcode,
    input  regsel, regdst, ALUSrcA, memread, memwrite, regwrite, memtoreg, jal, IorD,
    input  IRWrite, PCWrite, PCWriteCond, PCSrc, ALUSrcB, ALUOp, state, instr_done, retired
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the multicycle MIPS datapath, with retired-instruction counter.
// Define CTRL_ILLEGAL_TRAP_EN to trap on unlisted opcodes instead of treating them as no-ops.
module multicycle_controller (
  input logic                     clk,
  input logic                     rst,
  multicycle_controller_if.master ctrl
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9,
    StJal    = 4'd10,
    StAddiEx = 4'd11,
    StAddiWb = 4'd12,
    StTrap   = 4'd13
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  state_e      state_q, state_d;
  logic [31:0] retired_q, retired_d;
  logic        done_raw;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StFetch;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        case (ctrl.opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExec;
          OpBeq:      state_d = StBranch;
          OpJ:        state_d = StJump;
          OpJal:      state_d = StJal;
          OpAddi:     state_d = StAddiEx;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:    state_d = StTrap;
`else
          default:    state_d = StFetch;
`endif
        endcase
      end
      StMemAdr: state_d = (ctrl.opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd:  state_d = StMemWb;
      StExec:   state_d = StAluWb;
      StAddiEx: state_d = StAddiWb;
      StMemWb, StMemWr, StAluWb, StBranch, StJump, StJal, StAddiWb: state_d = StFetch;
`ifdef CTRL_ILLEGAL_TRAP_EN
      StTrap:   state_d = StTrap;
`endif
      default:  state_d = StFetch;
    endcase
    // The last state of every instruction is exactly the one that returns to fetch.
    done_raw  = (state_d == StFetch);
    retired_d = done_raw ? retired_q + 32'd1 : retired_q;
  end

  always_comb begin
    ctrl.regsel      = 1'b0;
    ctrl.regdst      = 1'b0;
    ctrl.ALUSrcA     = 1'b0;
    ctrl.memread     = 1'b0;
    ctrl.memwrite    = 1'b0;
    ctrl.regwrite    = 1'b0;
    ctrl.memtoreg    = 1'b0;
    ctrl.jal         = 1'b0;
    ctrl.IorD        = 1'b0;
    ctrl.IRWrite     = 1'b0;
    ctrl.PCWrite     = 1'b0;
    ctrl.PCWriteCond = 1'b0;
    ctrl.PCSrc       = 2'b00;
    ctrl.ALUSrcB     = 2'b00;
    ctrl.ALUOp       = 2'b00;
    ctrl.instr_done  = 1'b0;
    // Reset masks every strobe combinationally, before the first clock edge lands.
    if (rst) begin
      ctrl.instr_done = done_raw;
      unique case (state_q)
        StFetch: begin
          ctrl.memread = 1'b1;
          ctrl.IRWrite = 1'b1;
          ctrl.PCWrite = 1'b1;
          ctrl.ALUSrcB = 2'b01;
        end
        StDecode: ctrl.ALUSrcB = 2'b11;
        StMemAdr: begin
          ctrl.ALUSrcA = 1'b1;
          ctrl.ALUSrcB = 2'b10;
        end
        StMemRd: begin
          ctrl.memread = 1'b1;
          ctrl.IorD    = 1'b1;
        end
        StMemWb: begin
          ctrl.regwrite = 1'b1;
          ctrl.memtoreg = 1'b1;
        end
        StMemWr: begin
          ctrl.memwrite = 1'b1;
          ctrl.IorD     = 1'b1;
        end
        StExec: begin
          ctrl.ALUSrcA = 1'b1;
          ctrl.ALUOp   = 2'b10;
        end
        StAluWb: begin
          ctrl.regwrite = 1'b1;
          ctrl.regdst   = 1'b1;
        end
        StBranch: begin
          ctrl.ALUSrcA     = 1'b1;
          ctrl.ALUOp       = 2'b01;
          ctrl.PCWriteCond = 1'b1;
          ctrl.PCSrc       = 2'b10;
        end
        StJump: begin
          ctrl.PCWrite = 1'b1;
          ctrl.PCSrc   = 2'b01;
        end
        StJal: begin
          ctrl.PCWrite  = 1'b1;
          ctrl.PCSrc    = 2'b01;
          ctrl.regwrite = 1'b1;
          ctrl.regsel   = 1'b1;
          ctrl.jal      = 1'b1;
        end
        StAddiEx: begin
          ctrl.ALUSrcA = 1'b1;
          ctrl.ALUSrcB = 2'b10;
        end
        StAddiWb: ctrl.regwrite = 1'b1;
        default: ;
      endcase
    end
  end

  assign ctrl.state   = rst ? state_q : 4'd0;
  assign ctrl.retired = retired_q;

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Moore state machine that sequences the multicycle MIPS datapath. Consumes the 6-bit opcode held in the datapath's instruction register and drives every datapath control strobe (PC, memory, IR, register file, ALU operand and operation selects), one state per clock. Also provides a retired-instruction counter and a per-instruction completion pulse for bench and debug use.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-low reset; sampled on rising edge of clk
- opcode  in  6  instruction opcode from the datapath (inst[31:26]); sampled only in DECODE and MEMADR
- regsel, regdst, ALUSrcA, memread, memwrite, regwrite, memtoreg, jal, IorD, IRWrite, PCWrite, PCWriteCond  out  1 each  datapath strobes
- PCSrc  out  2  00 PC+4 (ALU result), 01 jump target, 10 ALUOut (branch target)
- ALUSrcB  out  2  00 B, 01 constant 4, 10 sign-extended imm, 11 sign-extended imm<<2
- ALUOp  out  2  00 add, 01 sub, 10 decode funct field
- state  out  4  current state encoding, debug
- instr_done  out  1  high in the last cycle of every instruction
- retired  out  32  count of completed instructions

## Operation
- Encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, JAL 10, ADDIEX 11, ADDIWB 12, TRAP 13.
- Outputs are decoded from the state only. Every strobe not listed for a state is 0. Every select not listed is 00.
- FETCH: memread, IRWrite, PCWrite, ALUSrcB=01. Next: DECODE.
- DECODE: ALUSrcB=11, which latches the branch target into ALUOut. Next is selected by opcode:
  - 100011 (lw) or 101011 (sw): MEMADR
  - 000000 (R-type): EXEC
  - 000100 (beq): BRANCH
  - 000010 (j): JUMP
  - 000011 (jal): JAL
  - 001000 (addi): ADDIEX
  - other: see Configuration
- MEMADR: ALUSrcA, ALUSrcB=10. Next: MEMRD if lw, MEMWR if sw.
- MEMRD: memread, IorD. Next: MEMWB.
- MEMWB: regwrite, memtoreg; regdst=0. Next: FETCH.
- MEMWR: memwrite, IorD. Next: FETCH.
- EXEC: ALUSrcA, ALUOp=10. Next: ALUWB.
- ALUWB: regwrite, regdst. Next: FETCH.
- BRANCH: ALUSrcA, ALUOp=01, PCWriteCond, PCSrc=10. Next: FETCH.
- JUMP: PCWrite, PCSrc=01. Next: FETCH.
- JAL: PCWrite, PCSrc=01, regwrite, regsel, jal. Register 31 receives the current PC, which is already PC+4. Next: FETCH.
- ADDIEX: ALUSrcA, ALUSrcB=10. Next: ADDIWB.
- ADDIWB: regwrite; regdst=0. Next: FETCH.
- instr_done is 1 exactly when the next state is FETCH. retired increments by 1 on each such edge and wraps from 0xFFFFFFFF to 0.

## Timing
- Cycles per instruction, FETCH to last state inclusive:
  - lw: 5
  - sw, R-type, addi: 4
  - beq, j, jal: 3
- Reset (rst low at a rising edge):
  - state becomes FETCH and retired becomes 0.
  - This applies in any state, including mid-instruction; a partially executed instruction is abandoned and not counted.
- While rst is low, all strobes, selects and instr_done are forced to 0, combinationally from rst. state shows 0.
- First fetch is issued in the first cycle after rst is sampled high.
- Changes on opcode outside DECODE and MEMADR have no effect.
- retired is updated on the same edge that leaves the final state, so it is visible in the FETCH cycle that follows.

## Configuration
- CTRL_ILLEGAL_TRAP_EN defined:
  - An unlisted opcode in DECODE moves to TRAP.
  - TRAP drives all strobes 0, holds, and does not assert instr_done.
  - Only reset leaves TRAP.
- CTRL_ILLEGAL_TRAP_EN undefined:
  - An unlisted opcode in DECODE returns to FETCH as a 2-cycle no-op.
  - instr_done is asserted in that DECODE cycle and the no-op is counted in retired.
  - TRAP is unreachable.

## Test plan
- Reset: hold rst=0 for 3 cycles, then release -> all outputs 0 during reset; next cycle state=0, memread=1, IRWrite=1, PCWrite=1, ALUSrcB=01.
- lw (opcode 100011) -> state sequence 0,1,2,3,4,0; MEMRD has IorD=1; MEMWB has memtoreg=1 and regwrite=1; retired increments by 1.
- R-type, then sw (101011), then addi (001000) back to back -> state sequences 0,1,6,7 / 0,1,2,5 / 0,1,11,12; memwrite high only in state 5; retired=3 after all three.
- beq (000100) then jal (000011) -> BRANCH has PCWriteCond=1, PCSrc=10, ALUOp=01; JAL has regsel=1, jal=1, regwrite=1, PCSrc=01; 3 cycles each.
- Reset mid-instruction: rst=0 while in MEMRD -> FETCH next cycle, retired=0, no MEMWB write occurs.
- Opcode 111111:
  - with CTRL_ILLEGAL_TRAP_EN: state=13 and held for 10 cycles, all strobes 0, retired unchanged.
  - without it: returns to FETCH after DECODE, retired increments by 1.
